gray_counter_stream: RTL and testbench
======================================

GRAY_COUNTER_STREAM -- requirements
Module: gray_counter_stream

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, giving the counter and code width in bits.
REQ-002 SHALL provide clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL provide rst, input, 1, synchronous active-high reset.
REQ-004 SHALL provide en, input, 1, request to run and produce code words.
REQ-005 SHALL provide load, input, 1, one-cycle command to preset the count.
REQ-006 SHALL provide load_bin, input, WIDTH, the binary preset value sampled when load=1.
REQ-007 SHALL provide ready, input, 1, downstream accepts gray_out this cycle.
REQ-008 SHALL provide valid, output, 1, gray_out/bin_out hold a word offered downstream.
REQ-009 SHALL provide gray_out, output, WIDTH, registered Gray code of the current count.
REQ-010 SHALL provide bin_out, output, WIDTH, registered binary count matching gray_out.
REQ-011 SHALL provide wrap, output, 1, registered one-cycle pulse on count wrap-around.

Function
REQ-012 SHALL hold an internal binary count; gray_out SHALL always equal bin_out ^ (bin_out >> 1), both registered in the same cycle.
REQ-013 SHALL implement FSM states IDLE (valid=0) and RUN (valid=1).
REQ-014 IDLE -> RUN SHALL occur on the edge where en=1, load=0; valid rises one cycle after en.
REQ-015 A transfer SHALL be valid=1 and ready=1 in the same cycle; the count SHALL advance by one, modulo 2^WIDTH, only on a transfer.
REQ-016 In RUN with valid=1 and ready=0, gray_out, bin_out and valid SHALL hold unchanged, regardless of en.
REQ-017 RUN -> IDLE SHALL occur on a transfer cycle with en=0; the count still advances.
REQ-018 wrap SHALL be 1 for exactly the one cycle in which the advanced value is presented after a transfer of the terminal value (all-ones when counting up); otherwise 0.
REQ-019 load=1 SHALL override everything except rst, in any state.
REQ-020 On load, the next cycle SHALL have bin_out=load_bin, gray_out=Gray of load_bin, state IDLE, valid=0 and wrap=0; an unaccepted word is discarded. This is the only permitted retraction of valid.
REQ-021 After load, REQ-014 SHALL apply from the following cycle.
REQ-022 ready SHALL be ignored while valid=0.

Reset
REQ-023 rst=1 SHALL, on the next edge, force state IDLE, count 0, valid=0, gray_out=0, bin_out=0 and wrap=0.
REQ-024 rst SHALL take priority over load, en and ready, including mid-handshake.

Configuration
REQ-025 Macro GRAY_UPDOWN_EN defined SHALL add port dir (input, 1; 0=up, 1=down), sampled on each transfer.
REQ-026 With dir=1, a transfer SHALL decrement the count modulo 2^WIDTH, and the terminal value for wrap SHALL be 0.
REQ-027 Without GRAY_UPDOWN_EN, the dir port SHALL be absent and counting SHALL be up only.

Structure
REQ-028 Shared package gray_pkg SHALL hold the default WIDTH constant, the FSM state typedef (IDLE, RUN) and the function bin2gray.
REQ-029 No sub-module SHALL be used; conversion SHALL call gray_pkg bin2gray on the next-count value before the register.

Verification
REQ-030 Reset: rst=1 for 2 cycles -> valid=0, gray_out=0000, bin_out=0000, wrap=0.
REQ-031 Free run: en=1, ready=1 from reset for 17 transfers -> gray 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000 with wrap=1 for that one cycle.
REQ-032 Backpressure: ready=0 for 3 cycles while gray_out=0011 -> gray_out holds 0011 and valid stays 1; ready=1 -> next word 0010.
REQ-033 Load mid-handshake: load=1, load_bin=1010 while valid=1, ready=0 -> next cycle valid=0, bin_out=1010, gray_out=1111; with en=1, valid=1 one cycle later.
REQ-034 GRAY_UPDOWN_EN: dir=1 from count 0000 -> next bin_out=1111, gray_out=1000, wrap=1; following transfer -> gray_out=1001.
REQ-035 Reset mid-run: rst=1 while valid=1, ready=0, bin_out=0101 -> next cycle all outputs 0 and state IDLE.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter stream.
//   DefaultWidth : default counter/code width in bits
//   gray_state_e : stream FSM state (StIdle: no word offered, StRun: word offered)
//   bin2gray     : binary to reflected-binary Gray conversion, valid for widths up to 32 bits
package gray_pkg;

  localparam int unsigned DefaultWidth = 4;
  localparam int unsigned MaxWidth     = 32;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } gray_state_e;

  // Operands are zero-extended to 32 bits by the caller; truncating the result back to the
  // caller's width gives the correct code because the extended MSB is always 0.
  function automatic logic [MaxWidth-1:0] bin2gray(input logic [MaxWidth-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_counter_stream.sv
// Gray-code counter with a valid/ready output stream.
// The count advances only when the offered word is accepted (valid & ready). load presets the
// count and returns to idle, discarding any unaccepted word; rst clears everything.
// Optional feature: define GRAY_UPDOWN_EN to add the dir port (0 = count up, 1 = count down).
//
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   en       : request to run and produce code words
//   load     : one-cycle preset command
//   load_bin : binary preset value, sampled when load = 1
//   ready    : downstream accepts the offered word this cycle
//   dir      : count direction, sampled on each transfer (GRAY_UPDOWN_EN only)
//   valid    : gray_out/bin_out hold a word offered downstream
//   gray_out : registered Gray code of the count
//   bin_out  : registered binary count
//   wrap     : one-cycle pulse when the wrapped value is presented
module gray_counter_stream
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  input  logic             ready,
`ifdef GRAY_UPDOWN_EN
  input  logic             dir,
`endif
  output logic             valid,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  gray_state_e      state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             count_dn;
  logic             xfer;
  logic [WIDTH-1:0] terminal;

`ifdef GRAY_UPDOWN_EN
  assign count_dn = dir;
`else
  assign count_dn = 1'b0;
`endif

  assign xfer     = (state_q == StRun) && ready;
  // Value whose transfer causes wrap-around in the current direction.
  assign terminal = count_dn ? '0 : '1;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    wrap_d  = 1'b0;
    if (load) begin
      bin_d   = load_bin;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en) state_d = StRun;
        end
        StRun: begin
          if (xfer) begin
            bin_d  = count_dn ? (bin_q - One) : (bin_q + One);
            wrap_d = (bin_q == terminal);
            if (!en) state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    gray_d = WIDTH'(bin2gray(MaxWidth'(bin_d)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      bin_q   <= '0;
      gray_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      wrap_q  <= wrap_d;
    end
  end

  assign valid    = (state_q == StRun);
  assign gray_out = gray_q;
  assign bin_out  = bin_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_counter_stream.sv
// Self-checking bench for gray_counter_stream (WIDTH = 4): fixed vector table, hand-written
// corner sequences, then randomized stimulus against a behavioural model.
module tb_gray_counter_stream;

  localparam int W = 4;
  localparam int Mod = 1 << W;

  logic         clk = 1'b0;
  logic         rst, en, load, ready, dir;
  logic [W-1:0] load_bin;
  logic         valid, wrap;
  logic [W-1:0] gray_out, bin_out;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_run;
  int m_cnt;
  bit m_wrap;

  always #5 clk = ~clk;

  gray_counter_stream #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_bin (load_bin),
    .ready    (ready),
`ifdef GRAY_UPDOWN_EN
    .dir      (dir),
`endif
    .valid    (valid),
    .gray_out (gray_out),
    .bin_out  (bin_out),
    .wrap     (wrap)
  );

  typedef struct {
    logic         rst;
    logic         en;
    logic         ready;
    logic         exp_valid;
    logic [W-1:0] exp_gray;
    logic [W-1:0] exp_bin;
    logic         exp_wrap;
  } vec_t;

  function automatic int gray_of(int b);
    return b ^ (b >> 1);
  endfunction

  // Apply inputs, clock once, sample 1 time unit after the edge and advance the model.
  task automatic step(input logic r, input logic l, input logic [W-1:0] lb, input logic e,
                      input logic rd, input logic d);
    bit down;
    rst = r; load = l; load_bin = lb; en = e; ready = rd; dir = d;
    @(posedge clk);
    #1;
`ifdef GRAY_UPDOWN_EN
    down = d;
`else
    down = 1'b0;
`endif
    if (r) begin
      m_run = 0; m_cnt = 0; m_wrap = 0;
    end else if (l) begin
      m_run = 0; m_cnt = int'(lb); m_wrap = 0;
    end else if (!m_run) begin
      m_wrap = 0;
      if (e) m_run = 1;
    end else if (rd) begin
      m_wrap = down ? (m_cnt == 0) : (m_cnt == Mod - 1);
      m_cnt  = down ? (m_cnt + Mod - 1) % Mod : (m_cnt + 1) % Mod;
      m_run  = e;
    end else begin
      m_wrap = 0;
    end
  endtask

  task automatic check(input string name, input logic v, input logic [W-1:0] g,
                       input logic [W-1:0] b, input logic w);
    checks++;
    if (valid !== v || gray_out !== g || bin_out !== b || wrap !== w) begin
      errors++;
      $display("FAIL %s: got valid=%b gray=%b bin=%b wrap=%b, want valid=%b gray=%b bin=%b wrap=%b",
               name, valid, gray_out, bin_out, wrap, v, g, b, w);
    end
  endtask

  task automatic check_model(input string name);
    check(name, m_run, W'(gray_of(m_cnt)), W'(m_cnt), m_wrap);
  endtask

  vec_t vecs[19];
  logic [W-1:0] gray_seq[16];

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; ready = 1'b0; dir = 1'b0; load_bin = '0;
    m_run = 0; m_cnt = 0; m_wrap = 0;

    gray_seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    // Two reset cycles, one enabling cycle, then 16 transfers ending in the wrap to 0000.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0};
    for (int j = 1; j <= 16; j++) begin
      vecs[2 + j] = '{1'b0, 1'b1, 1'b1, 1'b1, gray_seq[j % 16], W'(j % 16), (j == 16)};
    end

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].rst, 1'b0, '0, vecs[i].en, vecs[i].ready, 1'b0);
      check($sformatf("table[%0d]", i), vecs[i].exp_valid, vecs[i].exp_gray, vecs[i].exp_bin,
            vecs[i].exp_wrap);
    end

    // Backpressure while gray_out = 0011
    step(1, 0, '0, 0, 0, 0);
    check("bp_reset", 0, 4'b0000, 4'b0000, 0);
    step(0, 0, '0, 1, 0, 0);
    check("bp_start", 1, 4'b0000, 4'b0000, 0);
    step(0, 0, '0, 1, 1, 0);
    step(0, 0, '0, 1, 1, 0);
    check("bp_at_0011", 1, 4'b0011, 4'b0010, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, '0, k[0], 0, 0);
      check($sformatf("bp_hold%0d", k), 1, 4'b0011, 4'b0010, 0);
    end
    step(0, 0, '0, 1, 1, 0);
    check("bp_release", 1, 4'b0010, 4'b0011, 0);

    // Load mid-handshake discards the offered word
    step(0, 1, 4'b1010, 1, 0, 0);
    check("load_mid", 0, 4'b1111, 4'b1010, 0);
    step(0, 0, '0, 1, 1, 0);
    check("load_run", 1, 4'b1111, 4'b1010, 0);
    // Transfer with en=0 advances the count and drops to idle; ready then ignored
    step(0, 0, '0, 0, 1, 0);
    check("stop_xfer", 0, 4'b1110, 4'b1011, 0);
    step(0, 0, '0, 0, 1, 0);
    check("idle_ready", 0, 4'b1110, 4'b1011, 0);

    // Wrap pulse is cleared when the follow-up cycle is stalled
    step(0, 1, 4'b1111, 0, 0, 0);
    step(0, 0, '0, 1, 0, 0);
    step(0, 0, '0, 1, 1, 0);
    check("wrap_pulse", 1, 4'b0000, 4'b0000, 1);
    step(0, 0, '0, 1, 0, 0);
    check("wrap_clear", 1, 4'b0000, 4'b0000, 0);

    // Reset mid-run with bin_out = 0101, and reset over load
    step(0, 1, 4'b0101, 0, 0, 0);
    step(0, 0, '0, 1, 0, 0);
    check("pre_rst", 1, 4'b0111, 4'b0101, 0);
    step(1, 0, '0, 1, 0, 0);
    check("rst_mid", 0, 4'b0000, 4'b0000, 0);
    step(1, 1, 4'b1001, 1, 1, 0);
    check("rst_over_load", 0, 4'b0000, 4'b0000, 0);

`ifdef GRAY_UPDOWN_EN
    step(0, 0, '0, 1, 0, 1);
    check("dn_start", 1, 4'b0000, 4'b0000, 0);
    step(0, 0, '0, 1, 1, 1);
    check("dn_wrap", 1, 4'b1000, 4'b1111, 1);
    step(0, 0, '0, 1, 1, 1);
    check("dn_next", 1, 4'b1001, 4'b1110, 0);
`endif

    // Randomized run against the behavioural model
    step(1, 0, '0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(63) == 0), ($urandom_range(15) == 0), W'($urandom),
           ($urandom_range(3) != 0), $urandom_range(1) == 1, $urandom_range(1) == 1);
      check_model($sformatf("rand[%0d]", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
